// File: rtl/apb_regfile.sv
// apb_regfile: APB3 slave register file.
// REGWN read/write control registers sit at addresses 0..REGWN-1 and drive
// fabric logic directly. REGRN read-only status registers sit at
// REGR_ADDR_OFFSET.. and return the live regr_d slice. A successful status
// read emits a one-cycle regr_rd pulse for downstream clear-on-read logic.
// Every access phase is stretched by WAIT_STATES PREADY-low cycles.
// PRDATA, PREADY and PSLVERR are combinational so that a zero-wait transfer
// completes in its first access cycle. All three are forced low while
// PRESET is high.
module apb_regfile #(
  parameter int AWIDTH           = 4,
  parameter int DWIDTH           = 8,
  parameter int REGWN            = 5,
  parameter int REGRN            = 3,
  parameter int REGR_ADDR_OFFSET = 5,
  parameter int WAIT_STATES      = 0
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [AWIDTH-1:0]       PADDR,
  input  logic [DWIDTH-1:0]       PWDATA,
  output logic [DWIDTH-1:0]       PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  output logic [REGWN*DWIDTH-1:0] regw_q,
  output logic [REGWN-1:0]        regw_wr,
  input  logic [REGRN*DWIDTH-1:0] regr_d,
  output logic [REGRN-1:0]        regr_rd
);

  // Wait-state counter; 4 bits covers the full 0..15 WAIT_STATES range.
  logic [3:0]              cnt_r;

  // Transfer phase qualifiers.
  logic                    access_s;
  logic                    ready_s;
  logic                    done_s;

  // Address decode.
  logic [31:0]             addr_ext_s;
  logic [REGWN-1:0]        rw_sel_s;
  logic [REGRN-1:0]        ro_sel_s;
  logic                    rw_hit_s;
  logic                    ro_hit_s;
  logic                    unmapped_s;

  // Transfer outcome.
  logic                    err_s;
  logic                    wr_en_s;
  logic                    rd_ro_s;
  logic [DWIDTH-1:0]       rdata_s;

  // Register state.
  logic [REGWN*DWIDTH-1:0] regw_q_r;
  logic [REGWN-1:0]        regw_wr_r;
  logic [REGRN-1:0]        regr_rd_r;

  // Phase qualifiers; PRESET masks everything so the bus outputs fall
  // immediately on reset, without waiting for a clock edge.
  always_comb begin
    access_s = PSEL & PENABLE & ~PRESET;
    ready_s  = access_s & (cnt_r == 4'(WAIT_STATES));
    done_s   = ready_s;
  end

  // Wait counter: count PREADY-low access cycles, restart on completion or deselect.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_r <= 4'd0;
    end else if (!PSEL || done_s) begin
      cnt_r <= 4'd0;
    end else if (access_s) begin
      cnt_r <= cnt_r + 4'd1;
    end
  end

  // One-hot address decode for the RW block and the RO block.
  always_comb begin
    addr_ext_s = 32'(PADDR);
    rw_sel_s   = {REGWN{1'b0}};
    ro_sel_s   = {REGRN{1'b0}};
    for (int i = 0; i < REGWN; i++) begin
      rw_sel_s[i] = (addr_ext_s == 32'(i));
    end
    for (int j = 0; j < REGRN; j++) begin
      ro_sel_s[j] = (addr_ext_s == 32'(REGR_ADDR_OFFSET + j));
    end
    rw_hit_s   = |rw_sel_s;
    ro_hit_s   = |ro_sel_s;
    unmapped_s = ~(rw_hit_s | ro_hit_s);
  end

  // Outcome of the completing transfer: error, RW write, or RO read.
  always_comb begin
    err_s   = done_s & (unmapped_s | (PWRITE & ro_hit_s));
    wr_en_s = done_s & PWRITE & rw_hit_s;
    rd_ro_s = done_s & ~PWRITE & ro_hit_s;
  end

  // Read mux: OR of the selected slices; an unmapped address selects nothing.
  always_comb begin
    rdata_s = {DWIDTH{1'b0}};
    for (int i = 0; i < REGWN; i++) begin
      rdata_s = rdata_s | ({DWIDTH{rw_sel_s[i]}} & regw_q_r[i*DWIDTH +: DWIDTH]);
    end
    for (int j = 0; j < REGRN; j++) begin
      rdata_s = rdata_s | ({DWIDTH{ro_sel_s[j]}} & regr_d[j*DWIDTH +: DWIDTH]);
    end
  end

  // Control registers: load PWDATA into the addressed register on a good write.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      regw_q_r <= {(REGWN*DWIDTH){1'b0}};
    end else begin
      for (int i = 0; i < REGWN; i++) begin
        if (wr_en_s && rw_sel_s[i]) begin
          regw_q_r[i*DWIDTH +: DWIDTH] <= PWDATA;
        end
      end
    end
  end

  // Write strobes, aligned with the cycle in which the new value is visible.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      regw_wr_r <= {REGWN{1'b0}};
    end else begin
      regw_wr_r <= wr_en_s ? rw_sel_s : {REGWN{1'b0}};
    end
  end

  // Status read strobes, one cycle after a successful RO read completes.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      regr_rd_r <= {REGRN{1'b0}};
    end else begin
      regr_rd_r <= rd_ro_s ? ro_sel_s : {REGRN{1'b0}};
    end
  end

  // Bus and fabric outputs. PRDATA is driven only on a completing read.
  always_comb begin
    PREADY  = ready_s;
    PSLVERR = err_s;
    PRDATA  = (done_s & ~PWRITE) ? rdata_s : {DWIDTH{1'b0}};
    regw_q  = regw_q_r;
    regw_wr = regw_wr_r;
    regr_rd = regr_rd_r;
  end

endmodule

// File: doc/apb_regfile.md
# apb_regfile

Parametrised APB3 slave register file: REGWN read/write control registers and REGRN read-only status registers behind one APB port, with configurable wait states and PSLVERR signalling. It replaces the fixed 5-write / 3-read slave in the peripheral subsystem. Control registers drive fabric logic directly. Status registers sample fabric inputs, with per-register read strobes for clear-on-read logic downstream.

## Interface
- AWIDTH, 4, address width
- DWIDTH, 8, data width
- REGWN, 5, number of RW registers, addresses 0..REGWN-1
- REGRN, 3, number of RO registers
- REGR_ADDR_OFFSET, 5, address of RO register 0; legal only if ≥ REGWN and REGR_ADDR_OFFSET+REGRN ≤ 2^AWIDTH
- WAIT_STATES, 0, PREADY-low cycles inserted into every access phase (0..15)

- PCLK  in  1  clock; all state on rising edge
- PRESET  in  1  asynchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  AWIDTH  word address
- PWDATA  in  DWIDTH  write data
- PRDATA  out  DWIDTH  read data
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response, valid with PREADY
- regw_q  out  REGWN*DWIDTH  RW register contents; register i at bits [i*DWIDTH +: DWIDTH]
- regw_wr  out  REGWN  one-cycle pulse per RW register write
- regr_d  in  REGRN*DWIDTH  status inputs, same packing
- regr_rd  out  REGRN  one-cycle pulse per successful RO read

## Operation
- Reset values: regw_q = 0, regw_wr = 0, regr_rd = 0, wait counter = 0. PRDATA, PREADY, PSLVERR = 0 while PRESET is high.
- Access cycle: PSEL & PENABLE. Completion cycle: access cycle & PREADY.
- Wait counter (4 bits) increments in each access cycle where PREADY = 0. It clears on a completion cycle or on any cycle with PSEL = 0.
- PREADY = PSEL & PENABLE & (cnt == WAIT_STATES), combinational. It is 0 outside access cycles.
- Decode: RW hit if PADDR < REGWN. RO hit if REGR_ADDR_OFFSET ≤ PADDR < REGR_ADDR_OFFSET+REGRN. Otherwise unmapped.
- PSLVERR = completion & (unmapped | (PWRITE & RO hit)). It is 0 at all other times.
- Write, completion cycle with RW hit: regw_q[PADDR] ← PWDATA at the end of the cycle. regw_wr[PADDR] is high in the following cycle, aligned with the new regw_q value. A write with PSLVERR changes nothing.
- Read, completion cycle: PRDATA is combinational.
  - RW hit: PRDATA = regw_q slice.
  - RO hit: PRDATA = regr_d slice.
  - Unmapped: PRDATA = 0.
  - Any non-completion cycle: PRDATA = 0.
- A successful RO read pulses regr_rd[index] in the cycle after completion.
- Reads of RW registers generate no pulse.
- Write data equal to the current value still pulses regw_wr.

## Timing
- Zero-wait (WAIT_STATES = 0): setup cycle, then access cycle with PREADY = 1. Two cycles per transfer.
- N wait states: PREADY low for N access cycles, high on cycle N+1. Transfer takes N+2 cycles.
- Back-to-back transfers (new setup directly after completion) are supported. The counter restarts from 0 for each transfer.
- PSEL dropped mid-wait (protocol violation): counter clears, no register update, no pulses.
- PRESET asserted mid-transfer: everything returns to reset values immediately. The pending write is discarded. After PRESET deasserts, the master must restart with a setup cycle.
- PADDR, PWRITE and PWDATA are sampled only in the completion cycle. Their changes during wait cycles are ignored until completion.
- regr_d is sampled in the completion cycle only. No synchronisation is done here; inputs are assumed to be in the PCLK domain.

## Test plan
- Reset: assert PRESET mid-run → regw_q = 0, PRDATA/PREADY/PSLVERR/regw_wr/regr_rd = 0 the same cycle, no clock edge needed.
- Zero-wait RW: write 0xA5 to address 2 → PREADY=1 on the first access cycle, PSLVERR=0, regw_q[23:16] = 0xA5 and regw_wr = 5'b00100 the next cycle. Read address 2 → PRDATA = 0xA5.
- RO read: regr_d = {8'h33, 8'h22, 8'h11}, read address 6 → PRDATA = 0x22, PSLVERR=0, regr_rd = 3'b010 for one cycle after completion.
- Errors:
  - Write 0xFF to address 5 → PSLVERR=1, regw_q unchanged, no pulses.
  - Read address 9 → PSLVERR=1, PRDATA=0.
- WAIT_STATES=3: write to address 0 → PREADY low for exactly 3 access cycles, high on the 4th. Register updates only after the 4th. A back-to-back read of address 0 returns the new value with the same 3-cycle wait.
- Abort: WAIT_STATES=3, drop PSEL after 1 wait cycle (or pulse PRESET) → no regw change, no regw_wr. The next full transfer completes with full wait count.
